// File: rtl/axis_tag_pkg.sv
// Shared definitions for the field tagger and the downstream lookup stage:
// tagger FSM encoding and default tuser tag placement.
package axis_tag_pkg;

    typedef enum logic [1:0] {
        StClear,
        StAccum,
        StRelease
    } tag_state_e;

    localparam int unsigned DEFAULT_TAG_OFFSET    = 32;
    localparam int unsigned DEFAULT_TAG_VALID_BIT = 64;

endpackage

// File: rtl/axis_beat_fifo.sv
// First-word fall-through beat FIFO with full/empty flags and simultaneous push/pop.
// The head entry is visible on pop_data whenever empty is low.
module axis_beat_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             axis_aclk,
    input  logic             axis_resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/axis_field_tagger.sv
// Buffers one packet until the companion parser reports its field (or gives up),
// then forwards it with the field and a hit flag written into the first beat's tuser.
module axis_field_tagger #(
    parameter int unsigned TDATA_WIDTH   = 256,
    parameter int unsigned TKEEP_WIDTH   = TDATA_WIDTH / 8,
    parameter int unsigned TUSER_WIDTH   = 128,
    parameter int unsigned FIELD_WIDTH   = 32,
    parameter int unsigned TAG_OFFSET    = axis_tag_pkg::DEFAULT_TAG_OFFSET,
    parameter int unsigned TAG_VALID_BIT = axis_tag_pkg::DEFAULT_TAG_VALID_BIT,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic                   axis_aclk,
    input  logic                   axis_resetn,

    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,

    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,

    input  logic [FIELD_WIDTH-1:0] parsed_value,
    input  logic                   parsed_value_ready,
    output logic                   parser_reset,
    output logic [31:0]            tag_miss_count
);

    import axis_tag_pkg::*;

    localparam int unsigned BEAT_W = TDATA_WIDTH + TKEEP_WIDTH + TUSER_WIDTH + 1;

    tag_state_e             state;
    logic                   in_done;
    logic                   hit;
    logic                   first_beat;
    logic                   accepted_q;
    logic [FIELD_WIDTH-1:0] tag_reg;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [BEAT_W-1:0]      head;
    logic [TUSER_WIDTH-1:0] head_tuser;
    logic                   in_fire;
    logic                   out_fire;

    // Input stays closed in CLEAR and after the packet's tlast so only one packet is in flight.
    assign s_axis_tready = (state != StClear) && !fifo_full && !in_done;
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid = (state == StRelease) && !fifo_empty;
    assign out_fire      = m_axis_tvalid && m_axis_tready;
    assign parser_reset  = (state == StClear);

    axis_beat_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .axis_aclk   (axis_aclk),
        .axis_resetn (axis_resetn),
        .push        (in_fire),
        .push_data   ({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast}),
        .pop         (out_fire),
        .pop_data    (head),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    assign {m_axis_tdata, m_axis_tkeep, head_tuser, m_axis_tlast} = head;

    always_comb begin
        m_axis_tuser = head_tuser;
        if (first_beat) begin
            m_axis_tuser[TAG_OFFSET +: FIELD_WIDTH] = tag_reg;
            m_axis_tuser[TAG_VALID_BIT]             = hit;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state          <= StClear;
            in_done        <= 1'b0;
            hit            <= 1'b0;
            first_beat     <= 1'b1;
            accepted_q     <= 1'b0;
            tag_reg        <= '0;
            tag_miss_count <= '0;
        end else begin
            accepted_q <= in_fire;
            if (in_fire && s_axis_tlast) in_done <= 1'b1;

            unique case (state)
                StClear: begin
                    first_beat <= 1'b1;
                    state      <= StAccum;
                end
                StAccum: begin
                    if (parsed_value_ready) begin
                        tag_reg <= parsed_value;
                        hit     <= 1'b1;
                        state   <= StRelease;
                    // A beat taken last cycle may still produce a parser result next cycle.
                    end else if ((fifo_full || in_done) && !accepted_q) begin
                        tag_reg        <= '0;
                        hit            <= 1'b0;
                        tag_miss_count <= tag_miss_count + 32'd1;
                        state          <= StRelease;
                    end
                end
                StRelease: begin
                    if (out_fire) first_beat <= 1'b0;
                    if (out_fire && m_axis_tlast) begin
                        in_done <= 1'b0;
                        state   <= StClear;
                    end
                end
                default: state <= StClear;
            endcase
        end
    end

endmodule
